// File: rtl/daten_bus_io.sv
// daten_bus_io -- data-side interconnect between the CPU data port, the data
// RAM and a bank of memory-mapped I/O channel registers.
//
// Address bit 31 selects the target: 0 = RAM (pure combinational pass-through),
// 1 = I/O registers (IDLE -> ACK -> WAIT handshake, one write per held request).
// The block also stretches the CPU reset and rotates the I/O channels plus a
// debug value onto the LEDs.
//
// Ports:
//   Clock, Reset             system clock, synchronous active-high reset
//   LeseDaten/SchreibeDaten  CPU read/write requests (held until acknowledged)
//   DatenAdresse, DatenRaus  CPU address and write data
//   DatenRein                read data to CPU
//   DatenGeladen             read acknowledge
//   DatenGespeichert         write acknowledge
//   Ram*                     data RAM enables, address, write/read data, done flags
//   DebugWert                extra display slot
//   CpuReset                 stretched reset to the CPU
//   Led, AnzeigeKanal        display output and index of the slot shown
module daten_bus_io #(
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int IO_CHANNELS    = 4,
    parameter int LED_WIDTH      = 8,
    parameter int DWELL_CYCLES   = 2097152,
    parameter int RESET_CYCLES   = 4,
    localparam int SLOT_W        = $clog2(IO_CHANNELS + 1)
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      LeseDaten,
    input  logic                      SchreibeDaten,
    input  logic [31:0]               DatenAdresse,
    input  logic [DATA_WIDTH-1:0]     DatenRaus,
    output logic [DATA_WIDTH-1:0]     DatenRein,
    output logic                      DatenGeladen,
    output logic                      DatenGespeichert,
    output logic                      RamLesenAn,
    output logic                      RamSchreibenAn,
    output logic [RAM_ADDR_WIDTH-1:0] RamAdresse,
    output logic [DATA_WIDTH-1:0]     RamDatenRein,
    input  logic [DATA_WIDTH-1:0]     RamDatenRaus,
    input  logic                      RamDatenBereit,
    input  logic                      RamDatenGeschrieben,
    input  logic [LED_WIDTH-1:0]      DebugWert,
    output logic                      CpuReset,
    output logic [LED_WIDTH-1:0]      Led,
    output logic [SLOT_W-1:0]         AnzeigeKanal
);

    localparam int CH_IDX_W = (IO_CHANNELS > 1) ? $clog2(IO_CHANNELS) : 1;
    localparam int RST_W    = $clog2(RESET_CYCLES + 1);
    localparam int DWELL_W  = $clog2(DWELL_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_WAIT
    } io_state_e;

    // ---------------- reset sequencer ----------------
    logic [RST_W-1:0] rst_cnt_q;
    logic             cpu_rst_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rst_cnt_q <= RST_W'(RESET_CYCLES);
            cpu_rst_q <= 1'b1;
        end else if (rst_cnt_q != '0) begin
            rst_cnt_q <= rst_cnt_q - RST_W'(1);
            cpu_rst_q <= 1'b1;
        end else begin
            cpu_rst_q <= 1'b0;
        end
    end

    assign CpuReset = cpu_rst_q;

    // ---------------- address decode / RAM path ----------------
    logic                sel_io;
    logic                io_req;
    logic [CH_IDX_W-1:0] io_idx;
    logic                unused_addr;

    assign sel_io      = DatenAdresse[31];
    assign io_req      = LeseDaten | SchreibeDaten;
    assign io_idx      = DatenAdresse[CH_IDX_W-1:0];
    assign unused_addr = ^DatenAdresse;

    assign RamLesenAn     = LeseDaten & ~sel_io;
    assign RamSchreibenAn = SchreibeDaten & ~sel_io;
    assign RamAdresse     = DatenAdresse[RAM_ADDR_WIDTH-1:0];
    assign RamDatenRein   = DatenRaus;

    // ---------------- I/O FSM ----------------
    io_state_e             state_q, state_d;
    logic                  io_take;
    logic                  io_ack_rd, io_ack_wr;
    logic                  ack_rd_q, ack_wr_q;
    logic [DATA_WIDTH-1:0] rd_latch_q;
    logic [DATA_WIDTH-1:0] io_q [IO_CHANNELS];
    logic [DATA_WIDTH-1:0] io_rd_val;

    // Out-of-range indices match no channel, so reads yield 0 and writes vanish.
    always_comb begin
        io_rd_val = '0;
        for (int unsigned k = 0; k < IO_CHANNELS; k++) begin
            if (io_idx == CH_IDX_W'(k)) begin
                io_rd_val = io_q[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        io_take   = 1'b0;
        io_ack_rd = 1'b0;
        io_ack_wr = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (io_req && sel_io) begin
                    io_take = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                io_ack_rd = ack_rd_q;
                io_ack_wr = ack_wr_q;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (!io_req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            ack_rd_q   <= 1'b0;
            ack_wr_q   <= 1'b0;
            rd_latch_q <= '0;
            for (int unsigned k = 0; k < IO_CHANNELS; k++) begin
                io_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (io_take) begin
                ack_rd_q   <= LeseDaten;
                ack_wr_q   <= SchreibeDaten;
                rd_latch_q <= io_rd_val;
                for (int unsigned k = 0; k < IO_CHANNELS; k++) begin
                    if (SchreibeDaten && io_idx == CH_IDX_W'(k)) begin
                        io_q[k] <= DatenRaus;
                    end
                end
            end
        end
    end

    // Response mux follows the current address, independent of FSM state.
    assign DatenRein        = sel_io ? rd_latch_q : RamDatenRaus;
    assign DatenGeladen     = sel_io ? io_ack_rd  : RamDatenBereit;
    assign DatenGespeichert = sel_io ? io_ack_wr  : RamDatenGeschrieben;

    // ---------------- display rotation ----------------
    logic [DWELL_W-1:0]   dwell_q;
    logic [SLOT_W-1:0]    slot_q;
    logic [LED_WIDTH-1:0] led_q, led_d;

    always_comb begin
        led_d = DebugWert;
        for (int unsigned k = 0; k < IO_CHANNELS; k++) begin
            if (slot_q == SLOT_W'(k)) begin
                led_d = io_q[k][LED_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            dwell_q <= '0;
            slot_q  <= '0;
            led_q   <= '0;
        end else begin
            led_q <= led_d;
            if (dwell_q == DWELL_W'(DWELL_CYCLES - 1)) begin
                dwell_q <= '0;
                slot_q  <= (slot_q == SLOT_W'(IO_CHANNELS)) ? '0 : slot_q + SLOT_W'(1);
            end else begin
                dwell_q <= dwell_q + DWELL_W'(1);
            end
        end
    end

    assign Led          = led_q;
    assign AnzeigeKanal = slot_q;

endmodule

// File: tb/tb_daten_bus_io.sv
// Directed testbench for daten_bus_io. Instance A has 4 I/O channels, instance
// B has 3 (to exercise out-of-range channel addresses); both share inputs and
// use a display dwell of 4 cycles.
module tb_daten_bus_io;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        LeseDaten = 1'b0;
    logic        SchreibeDaten = 1'b0;
    logic [31:0] DatenAdresse = '0;
    logic [31:0] DatenRaus = '0;
    logic [31:0] RamDatenRaus = '0;
    logic        RamDatenBereit = 1'b0;
    logic        RamDatenGeschrieben = 1'b0;
    logic [7:0]  DebugWert = '0;

    logic [31:0] DatenRein_a, DatenRein_b;
    logic        DatenGeladen_a, DatenGeladen_b;
    logic        DatenGespeichert_a, DatenGespeichert_b;
    logic        RamLesenAn_a, RamLesenAn_b;
    logic        RamSchreibenAn_a, RamSchreibenAn_b;
    logic [7:0]  RamAdresse_a, RamAdresse_b;
    logic [31:0] RamDatenRein_a, RamDatenRein_b;
    logic        CpuReset_a, CpuReset_b;
    logic [7:0]  Led_a, Led_b;
    logic [2:0]  AnzeigeKanal_a;
    logic [1:0]  AnzeigeKanal_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    daten_bus_io #(.IO_CHANNELS(4), .DWELL_CYCLES(4), .RESET_CYCLES(4)) dut_a (
        .Clock(Clock), .Reset(Reset), .LeseDaten(LeseDaten), .SchreibeDaten(SchreibeDaten),
        .DatenAdresse(DatenAdresse), .DatenRaus(DatenRaus), .DatenRein(DatenRein_a),
        .DatenGeladen(DatenGeladen_a), .DatenGespeichert(DatenGespeichert_a),
        .RamLesenAn(RamLesenAn_a), .RamSchreibenAn(RamSchreibenAn_a), .RamAdresse(RamAdresse_a),
        .RamDatenRein(RamDatenRein_a), .RamDatenRaus(RamDatenRaus), .RamDatenBereit(RamDatenBereit),
        .RamDatenGeschrieben(RamDatenGeschrieben), .DebugWert(DebugWert), .CpuReset(CpuReset_a),
        .Led(Led_a), .AnzeigeKanal(AnzeigeKanal_a)
    );

    daten_bus_io #(.IO_CHANNELS(3), .DWELL_CYCLES(4), .RESET_CYCLES(4)) dut_b (
        .Clock(Clock), .Reset(Reset), .LeseDaten(LeseDaten), .SchreibeDaten(SchreibeDaten),
        .DatenAdresse(DatenAdresse), .DatenRaus(DatenRaus), .DatenRein(DatenRein_b),
        .DatenGeladen(DatenGeladen_b), .DatenGespeichert(DatenGespeichert_b),
        .RamLesenAn(RamLesenAn_b), .RamSchreibenAn(RamSchreibenAn_b), .RamAdresse(RamAdresse_b),
        .RamDatenRein(RamDatenRein_b), .RamDatenRaus(RamDatenRaus), .RamDatenBereit(RamDatenBereit),
        .RamDatenGeschrieben(RamDatenGeschrieben), .DebugWert(DebugWert), .CpuReset(CpuReset_b),
        .Led(Led_b), .AnzeigeKanal(AnzeigeKanal_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // One complete I/O transaction: request, ack one cycle later, wait, release.
    task automatic io_access(input string tag, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_a,
                             input logic [31:0] exp_b);
        DatenAdresse  = addr;
        DatenRaus     = wdata;
        SchreibeDaten = wr;
        LeseDaten     = !wr;
        #1;
        check_val({tag, "_ack_early"}, wr ? DatenGespeichert_a : DatenGeladen_a, 0);
        step();
        check_val({tag, "_ack_a"}, wr ? DatenGespeichert_a : DatenGeladen_a, 1);
        check_val({tag, "_ack_b"}, wr ? DatenGespeichert_b : DatenGeladen_b, 1);
        if (!wr) begin
            check_val({tag, "_data_a"}, DatenRein_a, exp_a);
            check_val({tag, "_data_b"}, DatenRein_b, exp_b);
        end
        step();
        check_val({tag, "_ack_drop"}, wr ? DatenGespeichert_a : DatenGeladen_a, 0);
        SchreibeDaten = 1'b0;
        LeseDaten     = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] seq [5];
        bit         found;
        logic [2:0] prev;
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h7F};

        // Reset held for 3 cycles, then 4 stretched cycles of CpuReset.
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("rst_cpu%0d", i), CpuReset_a, 1);
        end
        check_val("rst_led", Led_a, 0);
        check_val("rst_slot", AnzeigeKanal_a, 0);
        check_val("rst_wack", DatenGespeichert_a, 0);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val($sformatf("rel_cpu%0d", i), CpuReset_a, 1);
        end
        step();
        check_val("rel_cpu_low", CpuReset_a, 0);

        // RAM path pass-through.
        DatenAdresse   = 32'h0000_0005;
        LeseDaten      = 1'b1;
        RamDatenRaus   = 32'hDEAD_BEEF;
        RamDatenBereit = 1'b1;
        #1;
        check_val("ram_addr", RamAdresse_a, 32'h5);
        check_val("ram_rden", RamLesenAn_a, 1);
        check_val("ram_wren_off", RamSchreibenAn_a, 0);
        check_val("ram_rack", DatenGeladen_a, 1);
        check_val("ram_rdata", DatenRein_a, 32'hDEAD_BEEF);
        RamDatenBereit = 1'b0;
        #1;
        check_val("ram_rack_low", DatenGeladen_a, 0);
        LeseDaten           = 1'b0;
        SchreibeDaten       = 1'b1;
        DatenRaus           = 32'h1234_5678;
        RamDatenGeschrieben = 1'b1;
        #1;
        check_val("ram_wren", RamSchreibenAn_a, 1);
        check_val("ram_wdata", RamDatenRein_a, 32'h1234_5678);
        check_val("ram_wack", DatenGespeichert_a, 1);
        SchreibeDaten       = 1'b0;
        RamDatenGeschrieben = 1'b0;
        step();

        // I/O write held 5 cycles: exactly one write and one ack cycle.
        DatenAdresse  = 32'h8000_0002;
        DatenRaus     = 32'h0000_00A5;
        SchreibeDaten = 1'b1;
        #1;
        check_val("io_ram_wren_off", RamSchreibenAn_a, 0);
        check_val("io_wack_early", DatenGespeichert_a, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_val($sformatf("io_wack%0d", i), DatenGespeichert_a, (i == 0) ? 1 : 0);
            DatenRaus = 32'h0000_005A;
        end
        SchreibeDaten = 1'b0;
        step();
        io_access("io_rd2", 1'b0, 32'h8000_0002, 0, 32'hA5, 32'hA5);

        // Channel 3 is valid on A, out of range on B.
        io_access("oor_wr", 1'b1, 32'h8000_0003, 32'h77, 0, 0);
        io_access("oor_rd", 1'b0, 32'h8000_0003, 0, 32'h77, 32'h0);
        io_access("oor_ch2", 1'b0, 32'h8000_0002, 0, 32'hA5, 32'hA5);

        // Write requested in the same cycle as Reset must not happen.
        Reset         = 1'b1;
        DatenAdresse  = 32'h8000_0001;
        DatenRaus     = 32'h99;
        SchreibeDaten = 1'b1;
        step();
        check_val("midrst_wack", DatenGespeichert_a, 0);
        check_val("midrst_cpu", CpuReset_a, 1);
        Reset         = 1'b0;
        SchreibeDaten = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val($sformatf("midrst_rel%0d", i), CpuReset_a, 1);
        end
        step();
        check_val("midrst_cpu_low", CpuReset_a, 0);
        io_access("midrst_rd1", 1'b0, 32'h8000_0001, 0, 0, 0);

        // Display rotation with IO = {1,2,3,4} and DebugWert = 0x7F.
        DebugWert = 8'h7F;
        for (int k = 0; k < 4; k++) begin
            io_access($sformatf("disp_wr%0d", k), 1'b1, 32'h8000_0000 + k, k + 1, 0, 0);
        end
        found = 1'b0;
        prev  = AnzeigeKanal_a;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (AnzeigeKanal_a == 0 && prev != 0) found = 1'b1;
            prev = AnzeigeKanal_a;
        end
        check_val("disp_sync", found, 1);
        if (found) begin
            for (int j = 0; j < 24; j++) begin
                if (j > 0) step();
                check_val($sformatf("disp_slot%0d", j), AnzeigeKanal_a, (j / 4) % 5);
                check_val($sformatf("disp_led%0d", j), Led_a,
                          (j == 0) ? 8'h7F : seq[((j - 1) / 4) % 5]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/daten_bus_io.md
Name: daten_bus_io

Overview:
Data-side bus interconnect between the CPU data port, one data RAM and a bank of memory-mapped I/O channel registers. Address bit 31 selects the target: 0 routes to RAM, 1 routes to I/O. The block also sequences the CPU reset after the system reset. It rotates the I/O channels plus one debug value onto the LED outputs with a parametrised dwell time. It generalises the fixed single-LED-register arrangement to N channels with readback, a proper I/O handshake and a configurable display.

Parameters:
DATA_WIDTH, 32, CPU data width
RAM_ADDR_WIDTH, 8, word-address width passed to the data RAM
IO_CHANNELS, 4, number of I/O registers (1..16)
LED_WIDTH, 8, LED output width (≤ DATA_WIDTH)
DWELL_CYCLES, 2097152, clock cycles each display slot is shown (≥ 2)
RESET_CYCLES, 4, cycles CpuReset stays high after Reset falls (≥ 1)

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
LeseDaten  in  1  CPU read request (held until DatenGeladen)
SchreibeDaten  in  1  CPU write request (held until DatenGespeichert)
DatenAdresse  in  32  CPU data address
DatenRaus  in  DATA_WIDTH  CPU write data
DatenRein  out  DATA_WIDTH  read data to CPU
DatenGeladen  out  1  read acknowledge to CPU
DatenGespeichert  out  1  write acknowledge to CPU
RamLesenAn  out  1  RAM read enable
RamSchreibenAn  out  1  RAM write enable
RamAdresse  out  RAM_ADDR_WIDTH  RAM address
RamDatenRein  out  DATA_WIDTH  RAM write data
RamDatenRaus  in  DATA_WIDTH  RAM read data
RamDatenBereit  in  1  RAM read done
RamDatenGeschrieben  in  1  RAM write done
DebugWert  in  LED_WIDTH  extra display slot, e.g. instruction address
CpuReset  out  1  reset to CPU
Led  out  LED_WIDTH  display output
AnzeigeKanal  out  clog2(IO_CHANNELS+1)  index of the slot currently displayed

Behaviour:
- One clock domain; all state on posedge Clock.
- Reset is synchronous, active-high and takes priority over every other event.
- Reset values:
  - IO regs = 0, Led = 0, AnzeigeKanal = 0.
  - Dwell counter = 0, FSM = IDLE, I/O read latch = 0.
  - I/O acks = 0, CpuReset = 1.
- Reset sequencer:
  - CpuReset is 1 while Reset is high.
  - After Reset falls, CpuReset stays 1 for exactly RESET_CYCLES further cycles, then drops to 0.
  - It stays 0 until the next Reset.
- RAM path (DatenAdresse[31] = 0), purely combinational:
  - RamLesenAn = LeseDaten, RamSchreibenAn = SchreibeDaten.
  - RamAdresse = DatenAdresse[RAM_ADDR_WIDTH-1:0], RamDatenRein = DatenRaus.
  - DatenRein = RamDatenRaus, DatenGeladen = RamDatenBereit, DatenGespeichert = RamDatenGeschrieben.
  - Zero added latency.
- I/O path (DatenAdresse[31] = 1):
  - Ram enables forced to 0.
  - Channel index = DatenAdresse[clog2(IO_CHANNELS)-1:0], 1 bit minimum.
- I/O FSM, state IDLE:
  - Transitions on a request (LeseDaten | SchreibeDaten) with bit 31 = 1.
  - Write: IO[idx] <= DatenRaus; go to ACK.
  - Read: latch <= IO[idx], zero-extended; go to ACK.
  - Index ≥ IO_CHANNELS: write discarded, read returns 0, still acknowledged.
  - Both requests high: handled as a write; both acks asserted in ACK.
- I/O FSM, state ACK:
  - Exactly one cycle; the matching ack = 1 and DatenRein = latch.
  - Then go to WAIT.
- I/O FSM, state WAIT:
  - Acks = 0; return to IDLE once both requests are low.
  - Guarantees exactly one write per held request.
- I/O latency: request seen in cycle n → ack high in cycle n+1.
- Address bit 31 changing during ACK/WAIT has no effect on the FSM. RAM routing still follows the current address.
- Reset mid-transaction: FSM to IDLE; a write sampled in the same cycle as Reset is not performed.
- Display:
  - Dwell counter runs 0..DWELL_CYCLES-1 and wraps.
  - On wrap, AnzeigeKanal advances by 1, and wraps from IO_CHANNELS back to 0.
  - Slot k < IO_CHANNELS shows IO[k][LED_WIDTH-1:0]; slot IO_CHANNELS shows DebugWert.
  - Led is registered from the selected slot every cycle, so it tracks writes and DebugWert with 1-cycle latency.

Test Plan:
- Reset high 3 cycles, then low → CpuReset = 1 for 3+4 cycles, then 0. All outputs at their reset values during Reset.
- RAM read at address 0x00000005 → RamAdresse = 5, RamLesenAn = 1. DatenGeladen and DatenRein mirror RamDatenBereit and RamDatenRaus in the same cycle.
- I/O write 0xA5 to 0x80000002, request held 5 cycles → IO[2] = 0xA5 written once, DatenGespeichert high exactly 1 cycle. A read of 0x80000002 then returns 0x000000A5 one cycle after the request.
- IO_CHANNELS = 3: write to 0x80000003 → ack given, no register changes; read of 0x80000003 → DatenRein = 0.
- DWELL_CYCLES = 4, IO = {1,2,3,4}, DebugWert = 0x7F → Led sequence 1,2,3,4,0x7F,1 with each value held 4 cycles. AnzeigeKanal runs 0..4 and wraps.
- I/O write request asserted in the same cycle as Reset → IO unchanged, no ack. After release, CpuReset follows the reset sequence.
